alu_share_sched: RTL and testbench

Time-shares the single 8-bit ALU (ops, operands a/b, result y, flags parity/overflow/greater/less/is_eq) between NREQ requesters. The block arbitrates round-robin, drives registered operands into the ALU, captures the result and flags into a response register, and holds the response until the consumer takes it. It sits between the requester ports and the combinational ALU. Requesters never drive the ALU directly.

---
 rtl/alu_sched_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/alu_share_sched.sv | 83 ++++++++
 tb/tb_alu_share_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared FSM states, opcode width and response flag bit positions
package alu_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
    localparam int OPW = 2;
    localparam int FLG_PARITY = 4;
    localparam int FLG_OVF = 3;
    localparam int FLG_GT = 2;
    localparam int FLG_LT = 1;
    localparam int FLG_EQ = 0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_grant+1
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);
    int idx;
    always_comb begin
        grant = '0;
        grant_idx = '0;
        idx = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (enable && req[idx]) begin
                grant = '0;
                grant[idx] = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/alu_share_sched.sv
// alu_share_sched: time-shares one combinational ALU among NREQ requesters, one op in flight
module alu_share_sched #(
    parameter int NREQ = 4,
    parameter int W = 8,
    parameter int OPW = alu_sched_pkg::OPW,
    localparam int IW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*OPW-1:0] req_op,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [OPW-1:0]    alu_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_y,
    input  logic              alu_parity,
    input  logic              alu_overflow,
    input  logic              alu_greater,
    input  logic              alu_less,
    input  logic              alu_is_eq,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [W-1:0]      rsp_y,
    output logic [4:0]        rsp_flags,
    output logic [15:0]       ops_done
);
    import alu_sched_pkg::*;
    state_t state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_idx;
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req(req_valid),
        .last_grant(last_grant),
        .enable(state == IDLE),
        .grant(req_ready),
        .grant_idx(grant_idx)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= IW'(NREQ - 1);
            alu_op <= '0;
            alu_a <= '0;
            alu_b <= '0;
            rsp_valid <= 1'b0;
            rsp_id <= '0;
            rsp_y <= '0;
            rsp_flags <= '0;
            ops_done <= '0;
        end else begin
            case (state)
                IDLE: if (|req_ready) begin
                    alu_op <= req_op[int'(grant_idx)*OPW +: OPW];
                    alu_a <= req_a[int'(grant_idx)*W +: W];
                    alu_b <= req_b[int'(grant_idx)*W +: W];
                    rsp_id <= grant_idx;
                    last_grant <= grant_idx;
                    state <= ISSUE;
                end
                ISSUE: state <= CAPT;
                CAPT: begin
                    rsp_y <= alu_y;
                    rsp_flags[FLG_PARITY] <= alu_parity;
                    rsp_flags[FLG_OVF] <= alu_overflow;
                    rsp_flags[FLG_GT] <= alu_greater;
                    rsp_flags[FLG_LT] <= alu_less;
                    rsp_flags[FLG_EQ] <= alu_is_eq;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    ops_done <= (ops_done == 16'hFFFF) ? ops_done : ops_done + 16'd1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: directed vectors against a model ALU with a queue-based response scoreboard
module tb_alu_share_sched;
    typedef struct packed {logic [1:0] id; logic [7:0] y; logic [4:0] f;} exp_t;
    logic clk = 0, rst = 1, rsp_ready = 0, ovr = 0;
    logic [3:0] req_valid = 0, req_ready;
    logic [7:0] req_op = {2'd0, 2'd2, 2'd1, 2'd0};
    logic [31:0] req_a = {8'hC8, 8'hF0, 8'h50, 8'h12};
    logic [31:0] req_b = {8'h64, 8'hF0, 8'h20, 8'h34};
    logic [1:0] alu_op, rsp_id;
    logic [7:0] alu_a, alu_b, alu_y, rsp_y;
    logic alu_parity, alu_overflow, alu_greater, alu_less, alu_is_eq, rsp_valid;
    logic [4:0] rsp_flags;
    logic [15:0] ops_done, d0;
    logic [8:0] mr;
    logic [7:0] ey[4] = '{8'h46, 8'h30, 8'hF0, 8'h2C};
    logic [4:0] ef[4] = '{5'b10010, 5'b00100, 5'b00001, 5'b11100};
    logic [14:0] hold;
    exp_t q[$];
    exp_t oe, me;
    logic [1:0] oid;
    logic [1:0] grants[$];
    int gtimes[$];
    int cyc = 0, total = 0, bad = 0;

    alu_share_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .alu_parity(alu_parity), .alu_overflow(alu_overflow), .alu_greater(alu_greater),
        .alu_less(alu_less), .alu_is_eq(alu_is_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .ops_done(ops_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        case (alu_op)
            2'd0: mr = {1'b0, alu_a} + {1'b0, alu_b};
            2'd1: mr = {1'b0, alu_a} - {1'b0, alu_b};
            2'd2: mr = {1'b0, alu_a & alu_b};
            default: mr = {1'b0, alu_a ^ alu_b};
        endcase
        alu_y = ovr ? 8'hFF : mr[7:0];
        alu_parity = ovr ? 1'b1 : ^mr[7:0];
        alu_overflow = ovr ? 1'b1 : (alu_op < 2'd2) && mr[8];
        alu_greater = ovr ? 1'b1 : alu_a > alu_b;
        alu_less = ovr ? 1'b0 : alu_a < alu_b;
        alu_is_eq = ovr ? 1'b0 : alu_a == alu_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && (req_valid & req_ready) != 0) begin
            for (int i = 0; i < 4; i++) if (req_ready[i]) oid = 2'(i);
            oe.id = oid;
            oe.y = ovr ? 8'hFF : ey[oid];
            oe.f = ovr ? 5'b11100 : ef[oid];
            q.push_back(oe);
            grants.push_back(oid);
            gtimes.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) chk("rsp_unexpected", q.size(), 1);
            else begin
                me = q.pop_front();
                chk("sb_id", rsp_id, me.id);
                chk("sb_y", rsp_y, me.y);
                chk("sb_flags", rsp_flags, me.f);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        q.delete();
        grants.delete();
        gtimes.delete();
    endtask

    task automatic drain();
        #3;
        for (int i = 0; i < 40 && (q.size() != 0 || rsp_valid); i++) begin
            @(negedge clk);
            #3;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic issue_one(input logic [3:0] m);
        int n = grants.size();
        @(negedge clk);
        req_valid = m;
        #3;
        for (int i = 0; i < 20 && grants.size() == n; i++) begin
            @(negedge clk);
            #3;
        end
        chk("grant_seen", grants.size(), n + 1);
        @(negedge clk);
        req_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #3;
        chk("rst_outputs", {req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_y, rsp_flags}, 0);
        chk("rst_ops_done", ops_done, 0);
        @(negedge clk);
        rst = 0;
        // single request, response held until rsp_ready
        @(negedge clk);
        req_valid = 4'b0001;
        #3;
        chk("single_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 0;
        #3;
        chk("single_ready_drop", req_ready, 0);
        chk("single_alu", {alu_op, alu_a, alu_b}, {2'd0, 8'h12, 8'h34});
        chk("single_t1_valid", rsp_valid, 0);
        @(negedge clk);
        #3;
        chk("single_capt_valid", rsp_valid, 0);
        @(negedge clk);
        #3;
        chk("single_t2_valid", rsp_valid, 1);
        chk("single_y", rsp_y, 8'h46);
        chk("single_id", rsp_id, 0);
        @(negedge clk);
        rsp_ready = 1;
        @(negedge clk);
        #3;
        chk("single_done", ops_done, 1);
        chk("single_valid_clr", rsp_valid, 0);
        // round-robin with continuous requests
        do_reset();
        @(negedge clk);
        req_valid = 4'hF;
        #3;
        for (int i = 0; i < 40 && grants.size() < 5; i++) begin
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        req_valid = 0;
        drain();
        chk("rr_count", grants.size(), 5);
        for (int k = 0; k < grants.size() && k < 5; k++) chk("rr_order", grants[k], k % 4);
        for (int k = 1; k < gtimes.size() && k < 5; k++) chk("rr_gap", gtimes[k] - gtimes[k-1], 4);
        // back-pressure: r1 wins (last grant was 0), r2 waits
        @(negedge clk);
        rsp_ready = 0;
        req_valid = 4'b0110;
        d0 = ops_done;
        #3;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(negedge clk);
            #3;
        end
        chk("bp_valid", rsp_valid, 1);
        chk("bp_id", rsp_id, 1);
        hold = {rsp_id, rsp_flags, rsp_y};
        repeat (10) begin
            @(negedge clk);
            #3;
            chk("bp_hold", {rsp_valid, req_ready, rsp_id, rsp_flags, rsp_y}, {1'b1, 4'b0, hold});
        end
        @(negedge clk);
        rsp_ready = 1;
        @(negedge clk);
        #3;
        chk("bp_one_done", ops_done, d0 + 16'd1);
        chk("bp_valid_clr", rsp_valid, 0);
        for (int i = 0; i < 20 && grants.size() < 7; i++) begin
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        req_valid = 0;
        drain();
        chk("bp_next_grant", grants.size() > 6 ? grants[6] : 2'd3, 2);
        chk("bp_total_done", ops_done, d0 + 16'd2);
        // flag pass-through from overridden ALU
        ovr = 1;
        issue_one(4'b0001);
        drain();
        ovr = 0;
        // reset while in CAPT
        issue_one(4'b1000);
        #3;
        chk("mid_alu_a", alu_a, 8'hC8);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        #3;
        chk("mid_rst_outputs", {req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_y, rsp_flags}, 0);
        chk("mid_rst_ops_done", ops_done, 0);
        @(negedge clk);
        rst = 0;
        q.delete();
        grants.delete();
        gtimes.delete();
        issue_one(4'hF);
        chk("mid_first_grant", grants.size() > 0 ? grants[0] : 2'd3, 0);
        drain();
        // saturation
        @(negedge clk);
        force dut.ops_done = 16'hFFFE;
        @(negedge clk);
        release dut.ops_done;
        for (int k = 0; k < 3; k++) begin
            issue_one(4'b0001);
            drain();
            chk("sat_ops_done", ops_done, 16'hFFFF);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
